// File: rtl/alu_decoder_md.sv
// alu_decoder_md: Execute-stage ALU control decode plus an iterative
// multiply/divide engine with HI/LO registers and a hazard-unit stall.
module alu_decoder_md #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Funct,
  input  logic [1:0]       ALUOp,
  input  logic             valid_E,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  output logic             JR,
  output logic             shift,
  output logic             md_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             busy,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH-1:0]        r_hi, r_lo;
  logic [WIDTH-1:0]        r_acc_hi, r_acc_lo, r_opb;
  logic                    r_is_div, r_neg_q, r_neg_r;

  logic                    w_rtype, w_md, w_accept, w_start;
  logic                    w_mfhi, w_mflo, w_mthi, w_mtlo, w_mult, w_div;
  logic                    w_sgn, w_a_neg, w_b_neg;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic [WIDTH:0]          w_sum, w_rsh, w_trial;
  logic [WIDTH-1:0]        w_step_hi, w_step_lo, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0]      w_prod;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  // Magnitude of an operand; unsigned ops pass through untouched
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? f_neg(v) : v;
  endfunction

  // ALU operation select from ALUOp and funct
  always_comb begin
    ALUControl = 3'b000;
    case (ALUOp)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          6'b000000: ALUControl = 3'b100;
          6'b000010: ALUControl = 3'b101;
          6'b000011: ALUControl = 3'b011;
          default:   ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign w_rtype = (ALUOp == 2'b10);
  assign JR      = w_rtype & (Funct == 6'b001000);
  assign shift   = w_rtype & ((Funct == 6'b000000) | (Funct == 6'b000010) | (Funct == 6'b000011));

  assign w_mfhi  = w_rtype & (Funct == 6'b010000);
  assign w_mthi  = w_rtype & (Funct == 6'b010001);
  assign w_mflo  = w_rtype & (Funct == 6'b010010);
  assign w_mtlo  = w_rtype & (Funct == 6'b010011);
  assign w_mult  = w_rtype & (Funct[5:1] == 5'b01100);
  assign w_div   = w_rtype & (Funct[5:1] == 5'b01101);
  assign w_md    = w_rtype & ((Funct[5:2] == 4'b0100) | (Funct[5:2] == 4'b0110));

  // The issuing instruction is accepted only while idle, so busy never stalls it
  assign busy     = (r_state != S_IDLE);
  assign stall    = busy & valid_E & w_md;
  assign w_accept = valid_E & ~stall & w_md;
  assign w_start  = w_accept & (w_mult | (w_div & DIV_EN));

  assign md_sel    = valid_E & (w_mfhi | w_mflo);
  assign md_result = (valid_E & w_mfhi) ? r_hi : ((valid_E & w_mflo) ? r_lo : '0);

  // Funct[0] clear selects the signed variant (MULT, DIV)
  assign w_a_s   = SrcA;
  assign w_b_s   = SrcB;
  assign w_sgn   = ~Funct[0];
  assign w_a_neg = w_sgn & (w_a_s < 0);
  assign w_b_neg = w_sgn & (w_b_s < 0);

  // One shift-add or restoring shift-subtract step per RUN cycle
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    w_rsh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_trial = w_rsh - {1'b0, r_opb};
    if (r_is_div) begin
      if (!w_trial[WIDTH]) begin
        w_step_hi = w_trial[WIDTH-1:0];
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_rsh[WIDTH-1:0];
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX; divide-by-zero keeps quotient all ones
  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (r_is_div) begin
      w_res_lo = r_neg_q ? f_neg(r_acc_lo) : r_acc_lo;
      w_res_hi = r_neg_r ? f_neg(r_acc_hi) : r_acc_hi;
    end else begin
      if (r_neg_q) w_prod = f_neg2({r_acc_hi, r_acc_lo});
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // Engine next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Engine state and iteration counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)                r_cnt <= CW'(WIDTH);
      else if (r_state == S_RUN)  r_cnt <= r_cnt - CW'(1);
    end
  end

  // HI/LO architectural registers: MTHI/MTLO on accept, engine result in FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      if (w_accept & w_mthi) r_hi <= SrcA;
      if (w_accept & w_mtlo) r_lo <= SrcA;
    end
  end

  // Engine working registers; only meaningful outside IDLE, so left unreset
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_acc_hi <= '0;
      r_acc_lo <= f_mag(SrcA, w_a_neg);
      r_opb    <= f_mag(SrcB, w_b_neg);
      r_is_div <= w_div;
      r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(w_div & (SrcB == '0));
      r_neg_r  <= w_a_neg;
    end else if (r_state == S_RUN) begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
    end
  end

endmodule

// File: tb/tb_alu_decoder_md.sv
// tb_alu_decoder_md: directed bench for the ALU decoder and multiply/divide engine.
module tb_alu_decoder_md;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    Funct;
  logic [1:0]    ALUOp;
  logic          valid_E;
  logic [W-1:0]  SrcA, SrcB;
  logic [2:0]    ALUControl;
  logic          JR, shift, md_sel, busy, stall;
  logic [W-1:0]  md_result;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] ctl;
    logic       jr;
    logic       sh;
  } dec_t;

  dec_t dtab [14];

  always #5 clk = ~clk;

  alu_decoder_md #(.WIDTH(W), .DIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Funct(Funct), .ALUOp(ALUOp), .valid_E(valid_E),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .JR(JR), .shift(shift),
    .md_sel(md_sel), .md_result(md_result), .busy(busy), .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    valid_E = 1'b0;
    ALUOp   = 2'b00;
    Funct   = 6'b000000;
  endtask

  task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = 2'b10; Funct = fn; valid_E = 1'b1; SrcA = a; SrcB = b;
    tick();
    bubble();
    #1;
  endtask

  task automatic wait_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 200) begin
      c++;
      tick();
    end
  endtask

  task automatic count_stall(output int c);
    c = 0;
    while (stall === 1'b1 && c < 200) begin
      c++;
      tick();
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    ALUOp = 2'b10; valid_E = 1'b1;
    Funct = F_MFHI; #1; hi = md_result;
    Funct = F_MFLO; #1; lo = md_result;
    bubble();
  endtask

  task automatic run_md(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int c;
    logic [W-1:0] hi, lo;
    issue(fn, a, b);
    wait_busy(c);
    chk({tag, "_busy_cycles"}, 64'(c), 64'd33);
    read_hilo(hi, lo);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [W-1:0] hi, lo;

    dtab = '{
      '{2'b00, 6'b000000, 3'b010, 1'b0, 1'b0},
      '{2'b00, 6'b001000, 3'b010, 1'b0, 1'b0},
      '{2'b01, 6'b000000, 3'b110, 1'b0, 1'b0},
      '{2'b11, 6'b100000, 3'b000, 1'b0, 1'b0},
      '{2'b10, 6'b100000, 3'b010, 1'b0, 1'b0},
      '{2'b10, 6'b100010, 3'b110, 1'b0, 1'b0},
      '{2'b10, 6'b100100, 3'b000, 1'b0, 1'b0},
      '{2'b10, 6'b100101, 3'b001, 1'b0, 1'b0},
      '{2'b10, 6'b101010, 3'b111, 1'b0, 1'b0},
      '{2'b10, 6'b000000, 3'b100, 1'b0, 1'b1},
      '{2'b10, 6'b000010, 3'b101, 1'b0, 1'b1},
      '{2'b10, 6'b000011, 3'b011, 1'b0, 1'b1},
      '{2'b10, 6'b001000, 3'b000, 1'b1, 1'b0},
      '{2'b10, 6'b111111, 3'b000, 1'b0, 1'b0}
    };

    reset = 1'b1; SrcA = '0; SrcB = '0;
    bubble();
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    ALUOp = 2'b10; Funct = F_MULT; valid_E = 1'b1; #1;
    chk("rst_stall", 64'(stall), 64'd0);
    bubble();
    read_hilo(hi, lo);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Decode sweep with bubbles
    for (int i = 0; i < 14; i++) begin
      ALUOp = dtab[i].op; Funct = dtab[i].fn; valid_E = 1'b0; #1;
      chk($sformatf("dec%0d_ctl", i), 64'(ALUControl), 64'(dtab[i].ctl));
      chk($sformatf("dec%0d_jr", i), 64'(JR), 64'(dtab[i].jr));
      chk($sformatf("dec%0d_sh", i), 64'(shift), 64'(dtab[i].sh));
    end
    ALUOp = 2'b10; Funct = F_MFHI; valid_E = 1'b0; #1;
    chk("bubble_md_sel", 64'(md_sel), 64'd0);
    bubble();
    tick();

    // Engine arithmetic
    run_md("mult",   F_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("multu",  F_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
    run_md("div",    F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu0",  F_DIVU,  32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF);
    run_md("divmin", F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MULT immediately followed by MFLO
    ALUOp = 2'b10; Funct = F_MULT; valid_E = 1'b1; SrcA = 32'd5; SrcB = 32'd7;
    tick();
    Funct = F_MFLO; #1;
    count_stall(c);
    chk("mflo_stall_cycles", 64'(c), 64'd33);
    chk("mflo_md_sel", 64'(md_sel), 64'd1);
    chk("mflo_result", 64'(md_result), 64'd35);
    bubble();
    tick();

    // ADD behind a MULT is not stalled
    issue(F_MULT, 32'd2, 32'd3);
    ALUOp = 2'b10; Funct = F_ADD; valid_E = 1'b1; #1;
    chk("add_stall", 64'(stall), 64'd0);
    chk("add_ctl", 64'(ALUControl), 64'd2);
    bubble(); #1;
    wait_busy(c);
    chk("add_mult_busy", 64'(c), 64'd33);

    // MTHI then MFHI
    ALUOp = 2'b10; Funct = F_MTHI; valid_E = 1'b1; SrcA = 32'h12345678; #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    tick();
    Funct = F_MFHI; #1;
    chk("mfhi_result", 64'(md_result), 64'h12345678);
    chk("mfhi_stall", 64'(stall), 64'd0);
    bubble();
    tick();

    // MTLO while busy waits until the engine finishes
    issue(F_MULT, 32'd2, 32'd3);
    ALUOp = 2'b10; Funct = F_MTLO; valid_E = 1'b1; SrcA = 32'hAABBCCDD; #1;
    chk("mtlo_stalled", 64'(stall), 64'd1);
    count_stall(c);
    chk("mtlo_stall_cycles", 64'(c), 64'd33);
    tick();
    bubble();
    read_hilo(hi, lo);
    chk("mtlo_hi", 64'(hi), 64'd0);
    chk("mtlo_lo", 64'(lo), 64'hAABBCCDD);
    tick();

    // Reset in the middle of a divide
    issue(F_DIV, 32'd100, 32'd7);
    repeat (10) tick();
    chk("div_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1; #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    read_hilo(hi, lo);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    run_md("mult_after_rst", F_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
